// File: rtl/fns_cac_decoder.sv
// Receive-side FNS crosstalk-avoidance decoder: turns one Fibonacci-weighted codeword
// into binary by serial accumulation, and flags forbidden 010/101 patterns.
module fns_cac_decoder #(
  parameter int CW_W   = 8,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cw_valid,
  output logic              cw_ready,
  input  logic [CW_W-1:0]   cw_in,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_out
);

  localparam int CNT_W = (CW_W > 1) ? $clog2(CW_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW_W - 1);
  localparam logic [CNT_W-1:0] CNT_CHK  = CNT_W'(CW_W - 3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW_W-1:0]    sr_q, sr_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W:0]    wa_q, wa_d;
  logic [DATA_W:0]    wb_q, wb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               err_out_q, err_out_d;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holds valid and its payload steady until that edge.
  assign cw_ready   = (state_q == IDLE);
  assign data_valid = (state_q == DONE);
  assign data_out   = data_out_q;
  assign err_out    = err_out_q;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    wa_d       = wa_q;
    wb_d       = wb_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    data_out_d = data_out_q;
    err_out_d  = err_out_q;
    case (state_q)
      IDLE: begin
        if (cw_valid) begin
          sr_d    = cw_in;
          acc_d   = '0;
          wa_d    = (DATA_W+1)'(1);
          wb_d    = (DATA_W+1)'(2);
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sr_q[0]) acc_d = acc_q + wa_q[DATA_W-1:0];
        wa_d  = wb_q;
        wb_d  = wa_q + wb_q;
        sr_d  = sr_q >> 1;
        cnt_d = cnt_q + 1'b1;
        // Only windows lying fully inside the codeword are examined.
        if ((cnt_q <= CNT_CHK) && ((sr_q[2:0] == 3'b010) || (sr_q[2:0] == 3'b101)))
          err_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          data_out_d = err_d ? '0 : acc_d;
          err_out_d  = err_d;
        end
      end
      DONE: begin
        if (data_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      wa_q       <= '0;
      wb_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      err_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      wa_q       <= wa_d;
      wb_q       <= wb_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      err_out_q  <= err_out_d;
    end
  end

endmodule

// File: tb/tb_fns_cac_decoder.sv
// Directed self-checking bench for fns_cac_decoder (CW_W=8, DATA_W=7).
`timescale 1ns/1ps
module tb_fns_cac_decoder;

  localparam int CW_W   = 8;
  localparam int DATA_W = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cw_valid = 1'b0;
  logic              cw_ready;
  logic [CW_W-1:0]   cw_in = '0;
  logic              data_valid;
  logic              data_ready = 1'b1;
  logic [DATA_W-1:0] data_out;
  logic              err_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DATA_W:0] exp_q[$];

  fns_cac_decoder #(.CW_W(CW_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_in(cw_in),
    .data_valid(data_valid), .data_ready(data_ready), .data_out(data_out), .err_out(err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Call at a negedge; returns right after the accepting posedge with cw_valid still high.
  task automatic offer(input logic [CW_W-1:0] w, output int acc_cyc, output bit ok);
    int n;
    ok = 1'b0;
    acc_cyc = 0;
    cw_valid = 1'b1;
    cw_in = w;
    n = 0;
    while (!cw_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cw_ready) begin
      @(posedge clk);
      acc_cyc = cyc;
      ok = 1'b1;
    end
  endtask

  // Call at a negedge; k = accept-edge-relative edge count at which data_valid is first seen.
  task automatic send_and_wait(input logic [CW_W-1:0] w, output int k, output bit ok);
    int ac;
    bit acc_ok;
    offer(w, ac, acc_ok);
    @(negedge clk);
    cw_valid = 1'b0;
    k = 0;
    while (acc_ok && !data_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    ok = acc_ok && data_valid;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cw_ready !== 1'b1) begin failures++; $display("FAIL reset_cw_ready got=%b exp=1", cw_ready); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    checks++; if (data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%0d exp=0", data_out); end
    checks++; if (err_out !== 1'b0) begin failures++; $display("FAIL reset_err_out got=%b exp=0", err_out); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cw_ready !== 1'b1) begin failures++; $display("FAIL post_release_cw_ready got=%b exp=1", cw_ready); end
  endtask

  task automatic test_latency();
    int k;
    bit ok;
    send_and_wait(8'b0000_0001, k, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL latency_timeout got=%b exp=1", ok); end
    checks++; if (k != CW_W) begin failures++; $display("FAIL latency_edges got=%0d exp=%0d", k, CW_W); end
    checks++; if (data_out !== 7'd1) begin failures++; $display("FAIL latency_data got=%0d exp=1", data_out); end
    checks++; if (err_out !== 1'b0) begin failures++; $display("FAIL latency_err got=%b exp=0", err_out); end
    @(negedge clk);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL latency_valid_drop got=%b exp=0", data_valid); end
  endtask

  task automatic test_decode();
    logic [CW_W-1:0]   cw_t [5] = '{8'h80, 8'h06, 8'hFF, 8'h05, 8'h03};
    logic [DATA_W-1:0] dat_t[5] = '{7'd34, 7'd5, 7'd87, 7'd0, 7'd3};
    logic              err_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int k;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      send_and_wait(cw_t[i], k, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL decode_timeout cw=%b got=%b exp=1", cw_t[i], ok); end
      checks++; if (data_out !== dat_t[i]) begin failures++; $display("FAIL decode_data cw=%b got=%0d exp=%0d", cw_t[i], data_out, dat_t[i]); end
      checks++; if (err_out !== err_t[i]) begin failures++; $display("FAIL decode_err cw=%b got=%b exp=%b", cw_t[i], err_out, err_t[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int k;
    bit ok;
    data_ready = 1'b0;
    send_and_wait(8'hFF, k, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", ok); end
    cw_valid = 1'b1;
    cw_in = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold cyc=%0d got=%b exp=1", i, data_valid); end
      checks++; if (data_out !== 7'd87) begin failures++; $display("FAIL bp_data_hold cyc=%0d got=%0d exp=87", i, data_out); end
      checks++; if (cw_ready !== 1'b0) begin failures++; $display("FAIL bp_cw_ready cyc=%0d got=%b exp=0", i, cw_ready); end
    end
    cw_valid = 1'b0;
    data_ready = 1'b1;
    @(negedge clk);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", data_valid); end
    checks++; if (cw_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", cw_ready); end
  endtask

  task automatic test_back_to_back();
    logic [CW_W-1:0] cw_t [5] = '{8'h01, 8'h0C, 8'h18, 8'h5A, 8'h30};
    logic [DATA_W:0] exp_t[5] = '{{1'b0, 7'd1}, {1'b0, 7'd8}, {1'b0, 7'd13}, {1'b1, 7'd0}, {1'b0, 7'd21}};
    int acc_cyc[5];
    fork
      begin
        bit ok;
        for (int i = 0; i < 5; i++) begin
          exp_q.push_back(exp_t[i]);
          offer(cw_t[i], acc_cyc[i], ok);
          @(negedge clk);
        end
        cw_valid = 1'b0;
      end
      begin
        logic [DATA_W:0] exp;
        int n;
        for (int i = 0; i < 5; i++) begin
          n = 0;
          while (!data_valid && n < 100) begin
            @(negedge clk);
            n++;
          end
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          checks++; if ({err_out, data_out} !== exp || !data_valid) begin
            failures++;
            $display("FAIL b2b_result idx=%0d got=%b/%0d exp=%b/%0d valid=%b", i, err_out, data_out, exp[DATA_W], exp[DATA_W-1:0], data_valid);
          end
          @(negedge clk);
        end
      end
    join
    for (int i = 1; i < 5; i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] != CW_W + 2) begin
        failures++;
        $display("FAIL b2b_throughput idx=%0d got=%0d exp=%0d", i, acc_cyc[i] - acc_cyc[i-1], CW_W + 2);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int ac;
    int k;
    bit ok;
    bit seen_valid;
    offer(8'h06, ac, ok);
    @(negedge clk);
    cw_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (cw_ready !== 1'b1) begin failures++; $display("FAIL midrst_cw_ready got=%b exp=1", cw_ready); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL midrst_data_valid got=%b exp=0", data_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (data_valid) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_valid got=%b exp=0", seen_valid); end
    checks++; if (cw_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready_after got=%b exp=1", cw_ready); end
    send_and_wait(8'h06, k, ok);
    checks++; if (!ok || data_out !== 7'd5 || err_out !== 1'b0) begin
      failures++;
      $display("FAIL midrst_recover got=%b/%0d valid=%b exp=0/5", err_out, data_out, ok);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_decode();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
